mem_wb_stage: RTL

- Back end of the 16-bit MIPS pipeline: EX/MEM register, data memory, MEM/WB register and write-back mux in one block.
- Consumes the execute-stage results.
- Drives the feedback paths the front end expects:
  - register-file write port (RegWrite, write register, write data) to the decode stage;
  - PC_Src / branch target to the fetch stage;
  - pipeline flush to the IF/ID and ID/EX registers.

---
 rtl/mips_pkg.sv | 12 +
 rtl/mem_wb_stage_if.sv | 31 +++
 rtl/mem_wb_stage_data_memory.sv | 15 +
 rtl/mem_wb_stage.sv | 88 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and the EX/MEM control bundle for the 16-bit MIPS pipeline.
package mips_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
    logic reg_write;
  } ex_mem_ctl_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: execute-stage results in, branch redirect and write-back port out.
interface mem_wb_stage_if;
  import mips_pkg::*;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dest_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_zero;
  logic [DATA_W-1:0] ex_branch_target;
  logic              ex_mem_to_reg;
  logic              ex_reg_write;
  logic              pc_src;
  logic [DATA_W-1:0] branch_target;
  logic              flush;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_write_register;
  logic [DATA_W-1:0] wb_write_data;
  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_dest_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_zero, ex_branch_target, ex_mem_to_reg, ex_reg_write,
    input  pc_src, branch_target, flush, wb_reg_write, wb_write_register, wb_write_data
  );
  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_dest_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_zero, ex_branch_target, ex_mem_to_reg, ex_reg_write,
    output pc_src, branch_target, flush, wb_reg_write, wb_write_register, wb_write_data
  );
endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// data_memory: word-addressed RAM, asynchronous read, synchronous write, contents never reset.
module data_memory #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk) if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM register, data memory, MEM/WB register and write-back mux.
// Define MEM_ALIGN_CHECK_EN to add the sticky align_err output and suppress misaligned accesses.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DMEM_AW = 8
) (
  input logic clk,
  input logic rst_n,
`ifdef MEM_ALIGN_CHECK_EN
  output logic align_err,
`endif
  mem_wb_stage_if.slave bus
);
  logic              m_valid_q, m_zero_q;
  logic [DATA_W-1:0] m_alu_q, m_store_q, m_tgt_q;
  logic [REG_AW-1:0] m_dest_q;
  ex_mem_ctl_t       m_ctl_q, m_ctl_d;
  logic              w_valid_q, w_reg_write_q, w_reg_write_d, w_mem_to_reg_q;
  logic [REG_AW-1:0] w_dest_q;
  logic [DATA_W-1:0] w_alu_q, w_mem_q, rd_data;
  logic              mem_we, misalign;
  assign m_ctl_d = '{mem_read:   bus.ex_mem_read,
                     mem_write:  bus.ex_mem_write,
                     branch:     bus.ex_branch,
                     mem_to_reg: bus.ex_mem_to_reg,
                     reg_write:  bus.ex_reg_write};
`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  assign misalign  = m_valid_q & (m_ctl_q.mem_read | m_ctl_q.mem_write) & m_alu_q[0];
  assign align_err = align_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) align_err_q <= 1'b0;
    else        align_err_q <= align_err_q | misalign;
`else
  assign misalign = 1'b0;
`endif
  assign bus.pc_src        = m_valid_q & m_ctl_q.branch & m_zero_q;
  assign bus.flush         = bus.pc_src;
  assign bus.branch_target = m_tgt_q;
  assign mem_we            = m_valid_q & m_ctl_q.mem_write & ~misalign;
  assign w_reg_write_d     = m_ctl_q.reg_write & ~(misalign & m_ctl_q.mem_read);
  data_memory #(.AW(DMEM_AW), .DW(DATA_W)) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (m_alu_q[DMEM_AW:1]),
    .wdata_i (m_store_q),
    .rdata_o (rd_data)
  );
  // The instruction behind a taken branch is squashed as it enters M.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_zero_q  <= 1'b0;
      m_alu_q   <= '0;
      m_store_q <= '0;
      m_tgt_q   <= '0;
      m_dest_q  <= '0;
      m_ctl_q   <= '0;
    end else begin
      m_valid_q <= bus.ex_valid & ~bus.pc_src;
      m_zero_q  <= bus.ex_zero;
      m_alu_q   <= bus.ex_alu_result;
      m_store_q <= bus.ex_store_data;
      m_tgt_q   <= bus.ex_branch_target;
      m_dest_q  <= bus.ex_dest_reg;
      m_ctl_q   <= m_ctl_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_valid_q      <= 1'b0;
      w_reg_write_q  <= 1'b0;
      w_mem_to_reg_q <= 1'b0;
      w_dest_q       <= '0;
      w_alu_q        <= '0;
      w_mem_q        <= '0;
    end else begin
      w_valid_q      <= m_valid_q;
      w_reg_write_q  <= w_reg_write_d;
      w_mem_to_reg_q <= m_ctl_q.mem_to_reg;
      w_dest_q       <= m_dest_q;
      w_alu_q        <= m_alu_q;
      w_mem_q        <= rd_data;
    end
  assign bus.wb_write_data     = w_mem_to_reg_q ? w_mem_q : w_alu_q;
  assign bus.wb_reg_write      = w_valid_q & w_reg_write_q & (w_dest_q != '0);
  assign bus.wb_write_register = w_dest_q;
endmodule
